// File: rtl/conv_pkg.sv
// Shared sizing helpers for the streaming convolution engine: accumulator width,
// saturation limits and the number of results produced per frame.
package conv_pkg;

    function automatic int acc_width(input int data_w, input int k, input int frac);
        return 2 * data_w + $clog2(k * k) + frac + 1;
    endfunction

    function automatic longint sat_max(input int data_w);
        return (longint'(1) <<< (data_w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int data_w);
        return -(longint'(1) <<< (data_w - 1));
    endfunction

    function automatic int num_outputs(input int img_h, input int img_w, input int k, input int s);
        return ((img_h - k) / s + 1) * ((img_w - k) / s + 1);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of delay: each enabled cycle shifts a pixel in, and the pixel
// accepted DEPTH enables earlier appears on data_o.
module line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 58
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: the row storage is cleared on reset so stale pixels can never leak into
    // a window; this keeps it out of RAM inference but the row is short.
    // NOTE: sequential state uses non-blocking assignments so every stage shifts
    // from the values present before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (en_i) begin
            mem_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign data_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KxK convolution over a raster pixel stream: line buffers and a window
// feed a two-stage pipeline (products, then bias/shift/ReLU/saturate).
module conv_stream_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 58,
    parameter int IMG_H  = 58,
    parameter int K      = 3,
    parameter int S      = 1,
    parameter int FRAC   = 0,
    parameter int RELU   = 0
) (
    input  logic                  clk,
    input  logic                  global_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [K*K*DATA_W-1:0] weight,
    input  logic [DATA_W-1:0]     bias,
    output logic [DATA_W-1:0]     conv_op,
    output logic                  valid_conv,
    output logic                  end_conv
);

    localparam int PROD_W  = 2 * DATA_W;
    localparam int ACC_W   = acc_width(DATA_W, K, FRAC);
    localparam int COL_W   = $clog2(IMG_W + 1);
    localparam int ROW_W   = $clog2(IMG_H + 1);
    localparam int PH_W    = $clog2(S + 1);
    localparam int NUM_OUT = num_outputs(IMG_H, IMG_W, K, S);
    localparam int CNT_W   = $clog2(NUM_OUT + 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(DATA_W));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(DATA_W));

    if ((K > IMG_W) || (K > IMG_H) || (S < 1) || (K < 1)) begin : g_param_check
        $error("conv_stream_engine: illegal K/S for the configured frame size");
    end

    logic accept;
    assign accept = ce & in_valid;

    // Raster position of the next pixel, plus stride phases counted from K-1.
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PH_W-1:0]  col_ph_q, col_ph_d;
    logic [PH_W-1:0]  row_ph_q, row_ph_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             window_hit;
    logic             window_last;

    assign window_hit  = (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1))
                      && (row_ph_q == '0) && (col_ph_q == '0);
    assign window_last = (out_cnt_q == CNT_W'(NUM_OUT - 1));

    // NOTE: every always_comb output gets its hold value first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        col_ph_d  = col_ph_q;
        row_ph_d  = row_ph_q;
        out_cnt_d = out_cnt_q;
        if (accept) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d    = '0;
                col_ph_d = '0;
                if (row_q == ROW_W'(IMG_H - 1)) begin
                    row_d    = '0;
                    row_ph_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                    if (row_q >= ROW_W'(K - 1)) begin
                        row_ph_d = (row_ph_q == PH_W'(S - 1)) ? '0 : row_ph_q + 1'b1;
                    end
                end
            end else begin
                col_d = col_q + 1'b1;
                if (col_q >= COL_W'(K - 1)) begin
                    col_ph_d = (col_ph_q == PH_W'(S - 1)) ? '0 : col_ph_q + 1'b1;
                end
            end
            if (window_hit) begin
                out_cnt_d = window_last ? '0 : out_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            col_q     <= '0;
            row_q     <= '0;
            col_ph_q  <= '0;
            row_ph_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            col_ph_q  <= col_ph_d;
            row_ph_q  <= row_ph_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // tap[i] is the pixel i rows above the incoming one, same column.
    logic [DATA_W-1:0] tap [K];
    assign tap[0] = in_data;

    for (genvar i = 1; i < K; i++) begin : g_lb
        line_buffer #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W)
        ) u_line_buffer (
            .clk    (clk),
            .rst    (global_rst),
            .en_i   (accept),
            .data_i (tap[i-1]),
            .data_o (tap[i])
        );
    end

    logic signed [DATA_W-1:0] win_q [K][K];
    logic signed [DATA_W-1:0] win_d [K][K];

    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][K-1] = $signed(tap[K-1-r]);
        end
    end

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            win_q <= win_d;
        end
    end

    // Stage 1 multiplies the window as it will look after this pixel, which keeps
    // the completing pixel two enabled edges away from the result.
    logic signed [PROD_W-1:0] prod_d [K*K];
    logic signed [PROD_W-1:0] prod_q [K*K];
    logic                     v1_q;
    logic                     last1_q;

    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                prod_d[r*K+c] = PROD_W'(win_d[r][c])
                              * PROD_W'($signed(weight[(r*K+c)*DATA_W +: DATA_W]));
            end
        end
    end

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            for (int i = 0; i < K * K; i++) begin
                prod_q[i] <= '0;
            end
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
        end else if (ce) begin
            if (accept) begin
                prod_q <= prod_d;
            end
            v1_q    <= accept & window_hit;
            last1_q <= accept & window_hit & window_last;
        end
    end

    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_shr;
    logic [DATA_W-1:0]       res_d;

    always_comb begin
        acc_sum = ACC_W'($signed(bias)) <<< FRAC;
        for (int i = 0; i < K * K; i++) begin
            acc_sum = acc_sum + ACC_W'(prod_q[i]);
        end
        acc_shr = acc_sum >>> FRAC;
        if ((RELU != 0) && (acc_shr < 0)) begin
            acc_shr = '0;
        end
        if (acc_shr > SAT_HI) begin
            res_d = DATA_W'(SAT_HI);
        end else if (acc_shr < SAT_LO) begin
            res_d = DATA_W'(SAT_LO);
        end else begin
            res_d = acc_shr[DATA_W-1:0];
        end
    end

    // Strobes drop on a frozen edge so each result is flagged for one cycle only.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            conv_op    <= '0;
            valid_conv <= 1'b0;
            end_conv   <= 1'b0;
        end else if (ce) begin
            if (v1_q) begin
                conv_op <= res_d;
            end
            valid_conv <= v1_q;
            end_conv   <= v1_q & last1_q;
        end else begin
            valid_conv <= 1'b0;
            end_conv   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Scoreboard bench for conv_stream_engine on a 5x5 frame with a 3x3 kernel, run
// on four configurations (base, stride 2, ReLU, FRAC=1) sharing one pixel stream.
module tb_conv_stream_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            global_rst;
    logic            ce;
    logic            in_valid;
    logic [7:0]      in_data;
    logic [7:0]      w8 [4];
    logic [7:0]      b8 [4];
    logic [3:0][7:0] op;
    logic [3:0]      vld;
    logic [3:0]      endc;

    conv_stream_engine #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .K(3), .S(1), .FRAC(0), .RELU(0)) u_base (
        .clk(clk), .global_rst(global_rst), .ce(ce), .in_valid(in_valid), .in_data(in_data),
        .weight({9{w8[0]}}), .bias(b8[0]), .conv_op(op[0]), .valid_conv(vld[0]), .end_conv(endc[0]));
    conv_stream_engine #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .K(3), .S(2), .FRAC(0), .RELU(0)) u_s2 (
        .clk(clk), .global_rst(global_rst), .ce(ce), .in_valid(in_valid), .in_data(in_data),
        .weight({9{w8[1]}}), .bias(b8[1]), .conv_op(op[1]), .valid_conv(vld[1]), .end_conv(endc[1]));
    conv_stream_engine #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .K(3), .S(1), .FRAC(0), .RELU(1)) u_relu (
        .clk(clk), .global_rst(global_rst), .ce(ce), .in_valid(in_valid), .in_data(in_data),
        .weight({9{w8[2]}}), .bias(b8[2]), .conv_op(op[2]), .valid_conv(vld[2]), .end_conv(endc[2]));
    conv_stream_engine #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .K(3), .S(1), .FRAC(1), .RELU(0)) u_frac (
        .clk(clk), .global_rst(global_rst), .ce(ce), .in_valid(in_valid), .in_data(in_data),
        .weight({9{w8[3]}}), .bias(b8[3]), .conv_op(op[3]), .valid_conv(vld[3]), .end_conv(endc[3]));

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t exp_q [4][$];

    // Hand-computed results: window sum is 9x the window centre value.
    int l_pos  [9] = '{63, 72, 81, 108, 117, 126, 127, 127, 127};
    int l_neg  [9] = '{-63, -72, -81, -108, -117, -126, -128, -128, -128};
    int l_s2p  [9] = '{63, 81, 127, 127, 0, 0, 0, 0, 0};
    int l_s2n  [9] = '{-63, -81, -128, -128, 0, 0, 0, 0, 0};
    int l_zero [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int l_frac [9] = '{67, 76, 85, 112, 121, 127, 127, 127, 127};

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t_present = 0;
    bit lat_armed = 1'b0;
    logic ce_at_edge = 1'b0;

    always @(posedge clk) cyc++;
    always @(posedge clk) ce_at_edge <= ce;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (!ce_at_edge) check($sformatf("dut%0d valid after ce=0 edge", i), 32'(vld[i]), 0);
            if (vld[i]) begin
                if (exp_q[i].size() == 0) begin
                    check($sformatf("dut%0d unexpected result", i), 32'(vld[i]), 0);
                end else begin
                    e = exp_q[i].pop_front();
                    check($sformatf("dut%0d conv_op", i), 32'($signed(op[i])), e.data);
                    check($sformatf("dut%0d end_conv", i), 32'(endc[i]), 32'(e.last));
                    if (i == 0 && lat_armed) begin
                        // presented at t_present, accepted on the next edge, valid one edge later
                        check("first result latency", cyc, t_present + 2);
                        lat_armed = 1'b0;
                    end
                end
            end else if (endc[i]) begin
                check($sformatf("dut%0d end_conv without valid", i), 32'(endc[i]), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int dut, input int vals[9], input int n);
        for (int k = 0; k < n; k++) exp_q[dut].push_back('{data: vals[k], last: (k == n - 1)});
    endtask

    task automatic set_cfg(input bit neg);
        w8[0] = neg ? 8'hFF : 8'h01;
        w8[1] = neg ? 8'hFF : 8'h01;
        w8[2] = neg ? 8'h01 : 8'hFF;
        w8[3] = 8'h02;
        b8[0] = 8'd0;
        b8[1] = 8'd0;
        b8[2] = 8'd0;
        b8[3] = 8'd4;
    endtask

    task automatic expect_frame(input bit neg);
        if (neg) begin
            push(0, l_neg, 9);
            push(1, l_s2n, 4);
            push(2, l_pos, 9);
        end else begin
            push(0, l_pos, 9);
            push(1, l_s2p, 4);
            push(2, l_zero, 9);
        end
        push(3, l_frac, 9);
    endtask

    task automatic drive_pixel(input int p, input bit gaps, input bit arm);
        if (gaps) begin
            while ($urandom_range(0, 2) != 0) begin
                ce       = ($urandom_range(0, 1) != 0);
                in_valid = ce ? 1'b0 : ($urandom_range(0, 1) != 0);
                in_data  = 8'($urandom);
                tick();
            end
        end
        ce       = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'(p);
        if (arm && p == 13) begin
            t_present = cyc;
            lat_armed = 1'b1;
        end
        tick();
    endtask

    task automatic send_frame(input bit gaps, input bit arm);
        for (int p = 1; p <= 25; p++) drive_pixel(p, gaps, arm);
    endtask

    task automatic idle(input int n);
        ce       = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (n) tick();
    endtask

    task automatic drain();
        int waited = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
               && waited < 500) begin
            tick();
            waited++;
        end
        for (int i = 0; i < 4; i++) check($sformatf("dut%0d pending results", i), exp_q[i].size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s dut%0d conv_op", tag, i), 32'(op[i]), 0);
            check($sformatf("%s dut%0d valid_conv", tag, i), 32'(vld[i]), 0);
            check($sformatf("%s dut%0d end_conv", tag, i), 32'(endc[i]), 0);
        end
    endtask

    initial begin
        global_rst = 1'b1;
        ce         = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        set_cfg(1'b0);
        repeat (3) tick();
        check_reset_outputs("power-on reset");
        global_rst = 1'b0;
        idle(2);

        // Positive weights, continuous stream, latency probe on pixel 13.
        expect_frame(1'b0);
        send_frame(1'b0, 1'b1);
        idle(4);
        drain();

        // Negative weights: negative saturation, ReLU on positive sums.
        set_cfg(1'b1);
        idle(2);
        expect_frame(1'b1);
        send_frame(1'b0, 1'b0);
        idle(4);
        drain();

        // Random ce / in_valid gaps must not change the result sequence.
        set_cfg(1'b0);
        idle(2);
        expect_frame(1'b0);
        send_frame(1'b1, 1'b0);
        idle(4);
        drain();

        // Reset mid-frame, then two back-to-back frames.
        for (int p = 1; p <= 10; p++) drive_pixel(p, 1'b0, 1'b0);
        global_rst = 1'b1;
        in_valid   = 1'b0;
        tick();
        tick();
        check_reset_outputs("mid-frame reset");
        global_rst = 1'b0;
        expect_frame(1'b0);
        expect_frame(1'b0);
        send_frame(1'b0, 1'b0);
        send_frame(1'b0, 1'b0);
        idle(4);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
